seq_gen_tx: RTL and testbench
=============================

# seq_gen_tx

Serial pattern transmitter: accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on the single-bit line `a`, one bit per `en` tick. It sits upstream of the `0→1` Mealy sequence detector and shares that detector's `clk`, `rst_n` and `en`. It also keeps a running count of the `0→1` transitions it has put on the line, so benches can check the detector's `y` pulses against it.

## Interface
- `WIDTH`, default 8: data word width in bits, ≥2.
- `CNT_W`, default 8: width of the expected-hit counter.

Ports (clock and reset first):
- `clk` in 1: clock clk.
- `rst_n` in 1: reset rst_n, asynchronous, active-low.
- `en` in 1: bit-rate tick; the same strobe the detector uses.
- `in_valid` in 1: word offered.
- `in_ready` out 1: block can accept a word.
- `in_data` in `WIDTH`: word to send.
- `a` out 1: serial line, registered; idle level 1.
- `busy` out 1: a word or parity bit is being sent.
- `done` out 1: one-clk pulse after the final bit is consumed.
- `exp_hits` out `CNT_W`: count of en-sampled `0→1` transitions on `a`.

## Operation
- States: IDLE, SHIFT, PARITY. PARITY exists only with the macro defined.
- IDLE:
  - `a`=1, `in_ready`=1, `busy`=0.
  - When `in_valid & in_ready` at a clk edge: load the shift register with `in_data`, clear the bit counter, enter SHIFT. `en` is not required for this.
- SHIFT:
  - `a` = shift register MSB; `busy`=1.
  - On each clk edge with `en`=1: shift left and increment the bit counter.
  - When the counter equals `WIDTH-1` on an `en` edge: go to PARITY if enabled, otherwise go to IDLE with `done`=1 for one clk.
- PARITY: `a` = even parity of the loaded word. The next `en` edge moves to IDLE with `done` pulsed.
- `en`=0 freezes state, shift register, counter and `exp_hits`. The handshake still completes in IDLE.
- Hit tracking: register `prev` holds `a` as sampled at the last `en` edge, idle 1s included. On each `en` edge, `exp_hits` increments when `prev`=0 and `a`=1.
  - This mirrors the detector exactly, including a `0→1` formed by a word's last bit 0 followed by the idle 1.
  - `exp_hits` wraps modulo 2^`CNT_W`.
- `in_data` is ignored when not accepted. `in_ready`=0 in SHIFT and PARITY; a word offered then waits.

## Timing
- Reset values (async, immediate): state IDLE, `a`=1, `prev`=1, `in_ready`=1, `busy`=0, `done`=0, `exp_hits`=0, shift register and counter 0.
- Reset mid-word aborts the word; no `done` pulse.
- Accept at edge N: `a` shows the MSB from N+1 and holds it until the first `en` edge after N, exclusive of edge N itself.
- Each bit occupies exactly one `en` interval. The detector samples the same value on the same edge.
- `done` is high in the first clk cycle in IDLE. `in_ready` rises in the same cycle, so the earliest back-to-back accept is at the end of that cycle.
- Word latency is `WIDTH` `en` ticks, plus 1 with parity.
- `exp_hits` updates one clk after the sampling `en` edge, the same cycle as the detector's state change.

## Configuration
- Macro: `SEQ_GEN_TX_PARITY_EN`.
- Defined: the PARITY state is present, and one even-parity bit follows the data bit sequence (XOR of all data bits). The parity bit participates in `exp_hits`.
- Undefined: no PARITY state; SHIFT goes directly to IDLE. The state encoding may shrink.

## Structure
- Shared package `seq_gen_pkg`:
  - state enum typedef (IDLE/SHIFT/PARITY);
  - `LINE_IDLE` = 1'b1;
  - default widths.
- Sub-module `edge01_counter`: takes `clk`, `rst_n`, `en` and `a`; holds `prev` and produces `exp_hits`. The testbench reuses it as a scoreboard model.

## Test plan
- Idle after reset with `en` every cycle: `a`=1, `exp_hits`=0, `in_ready`=1, no `done`.
- `WIDTH`=8, `in_data`=0x55, `en` every cycle:
  - `a` sequence 0,1,0,1,0,1,0,1;
  - `done` pulses 1 clk after the 8th `en` edge;
  - `exp_hits`=4; detector `y` count = 4.
- `in_data`=0xF0, then one idle `en` tick:
  - `exp_hits`=0 during the word;
  - becomes 1 on the idle tick (`0→1` into the idle level).
- `en` every 4th cycle, 0xA3:
  - each bit held exactly 4 clks;
  - `in_valid` re-asserted while `busy` is not accepted until the cycle `done` is high.
- Reset pulse after 3 bits of 0x0F: `a`=1, `busy`=0, `exp_hits`=0 immediately; no `done`.
- With `SEQ_GEN_TX_PARITY_EN`, 0x07: 9 bits sent, 9th = 1; `done` after the 9th `en` edge; `exp_hits`=1.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// SEQ_GEN_TX_PARITY_EN adds the PARITY state to the encoding.
package seq_gen_pkg;

    localparam logic LINE_IDLE = 1'b1;
    localparam int   DEF_WIDTH = 8;
    localparam int   DEF_CNT_W = 8;

`ifdef SEQ_GEN_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;
`endif

endpackage

// File: rtl/edge01_counter.sv
// Counts en-sampled 0->1 transitions on the serial line, exactly as the
// downstream Mealy detector sees them (idle 1s included).
module edge01_counter
    import seq_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    output logic [CNT_W-1:0] exp_hits
);

    logic             prev_q, prev_d;
    logic [CNT_W-1:0] hits_q, hits_d;

    always_comb begin
        prev_d = prev_q;
        hits_d = hits_q;
        if (en) begin
            prev_d = a;
            if (!prev_q && a) begin
                hits_d = hits_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= LINE_IDLE;
            hits_q <= '0;
        end else begin
            prev_q <= prev_d;
            hits_q <= hits_d;
        end
    end

    assign exp_hits = hits_q;

endmodule

// File: rtl/seq_gen_tx.sv
// MSB-first serial transmitter with 0->1 hit tracking.
// Define SEQ_GEN_TX_PARITY_EN to append an even-parity bit to each word.
module seq_gen_tx
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             a,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] exp_hits
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             done_q, done_d;
`ifdef SEQ_GEN_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // a_d is the line level for the state being entered, so a stays registered
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        done_d  = 1'b0;
`ifdef SEQ_GEN_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                a_d = LINE_IDLE;
                if (in_valid) begin
                    sh_d    = in_data;
                    cnt_d   = '0;
                    a_d     = in_data[WIDTH-1];
                    state_d = SHIFT;
`ifdef SEQ_GEN_TX_PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            SHIFT: begin
                if (en) begin
                    sh_d  = sh_q << 1;
                    cnt_d = cnt_q + CW'(1);
                    a_d   = sh_q[WIDTH-2];
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
`ifdef SEQ_GEN_TX_PARITY_EN
                        a_d     = par_q;
                        state_d = PARITY;
`else
                        a_d     = LINE_IDLE;
                        done_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef SEQ_GEN_TX_PARITY_EN
            PARITY: begin
                if (en) begin
                    a_d     = LINE_IDLE;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                a_d     = LINE_IDLE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            a_q     <= LINE_IDLE;
            done_q  <= 1'b0;
`ifdef SEQ_GEN_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            done_q  <= done_d;
`ifdef SEQ_GEN_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign a        = a_q;
    assign done     = done_q;
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    edge01_counter #(
        .CNT_W(CNT_W)
    ) u_hits (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .a       (a_q),
        .exp_hits(exp_hits)
    );

endmodule

// File: tb/tb_seq_gen_tx.sv
// Bench for seq_gen_tx: hand-computed word vectors, corner sequences and
// random words checked every cycle against a bit-queue line model.
module tb_seq_gen_tx;

`ifdef SEQ_GEN_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       a;
    logic       busy;
    logic       done;
    logic [7:0] exp_hits;

    seq_gen_tx #(
        .WIDTH(8),
        .CNT_W(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .a       (a),
        .busy    (busy),
        .done    (done),
        .exp_hits(exp_hits)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // line model: bits still to send, current line level, detector view
    bit       m_active;
    bit       m_line;
    bit       m_prev;
    bit       m_done;
    bit       m_acc;
    bit       m_rem[$];
    bit [7:0] m_hits;

    int cyc    = 0;
    int period = 1;

    typedef struct {
        logic [7:0] data;
        int         per;
        int         hits_np;
        int         hits_p;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_line   = 1'b1;
        m_prev   = 1'b1;
        m_done   = 1'b0;
        m_acc    = 1'b0;
        m_hits   = '0;
        m_rem.delete();
    endtask

    task automatic en_tick();
        en = ((cyc % period) == 0);
        cyc++;
    endtask

    // one clock: model the edge, then compare every output mid-cycle
    task automatic step();
        @(posedge clk);
        if (en) begin
            if (!m_prev && m_line) m_hits++;
            m_prev = m_line;
        end
        m_done = 1'b0;
        m_acc  = 1'b0;
        if (!m_active) begin
            if (in_valid) begin
                m_active = 1'b1;
                m_acc    = 1'b1;
                m_line   = in_data[7];
                m_rem.delete();
                for (int i = 6; i >= 0; i--) m_rem.push_back(in_data[i]);
`ifdef SEQ_GEN_TX_PARITY_EN
                m_rem.push_back(^in_data);
`endif
            end
        end else if (en) begin
            if (m_rem.size() == 0) begin
                m_active = 1'b0;
                m_line   = 1'b1;
                m_done   = 1'b1;
            end else begin
                m_line = m_rem.pop_front();
            end
        end
        @(negedge clk);
        chk("a", a, m_line);
        chk("busy", busy, m_active);
        chk("in_ready", in_ready, !m_active);
        chk("done", done, m_done);
        chk("exp_hits", exp_hits, m_hits);
    endtask

    task automatic wait_accept();
        int g = 0;
        do begin
            en_tick();
            step();
            g++;
        end while (!m_acc && g < 100);
        chk("accept_seen", m_acc, 1);
    endtask

    task automatic wait_done();
        int ticks = 0;
        int g     = 0;
        do begin
            en_tick();
            step();
            if (en) ticks++;
            g++;
        end while (done !== 1'b1 && g < 200);
        chk("done_seen", done, 1);
        chk("latency", ticks, NB);
    endtask

    task automatic idle_ticks(input int n);
        int k = 0;
        int g = 0;
        while (k < n && g < 100) begin
            en_tick();
            step();
            if (en) k++;
            g++;
        end
    endtask

    task automatic send_word(input logic [7:0] d, input int per,
                             input int exp_delta);
        bit [7:0] base;
        base     = m_hits;
        period   = per;
        in_data  = d;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        in_data  = ~d;
        wait_done();
        idle_ticks(1);
        chk("word_hits", exp_hits, 32'(8'(base + 8'(exp_delta))));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h55, 1, 4, 5};
        tbl[1] = '{8'hF0, 1, 1, 1};
        tbl[2] = '{8'hA3, 4, 2, 3};
        tbl[3] = '{8'h0F, 1, 1, 2};
        tbl[4] = '{8'h00, 1, 1, 1};
        tbl[5] = '{8'hFF, 2, 0, 1};
        tbl[6] = '{8'h01, 1, 1, 1};
        tbl[7] = '{8'h80, 3, 1, 1};
        tbl[8] = '{8'hAA, 3, 4, 4};
        tbl[9] = '{8'h07, 1, 1, 1};

        rst_n    = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_a", a, 1);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hits", exp_hits, 0);
        rst_n = 1'b1;

        period = 1;
        for (int i = 0; i < 5; i++) begin
            en_tick();
            step();
        end

        for (int i = 0; i < 10; i++) begin
`ifdef SEQ_GEN_TX_PARITY_EN
            send_word(tbl[i].data, tbl[i].per, tbl[i].hits_p);
`else
            send_word(tbl[i].data, tbl[i].per, tbl[i].hits_np);
`endif
        end

        // F0: no hit while the word is on the line, one on the idle tick
        begin
            bit [7:0] base;
            base     = m_hits;
            period   = 1;
            in_data  = 8'hF0;
            in_valid = 1'b1;
            wait_accept();
            in_valid = 1'b0;
            wait_done();
            chk("f0_in_word", exp_hits, 32'(base));
            idle_ticks(1);
            chk("f0_idle", exp_hits, 32'(8'(base + 8'd1)));
        end

        // A3 at en/4 with a second word held on in_valid: taken at done
        begin
            int g = 0;
            period   = 4;
            cyc      = 0;
            in_data  = 8'hA3;
            in_valid = 1'b1;
            wait_accept();
            in_data = 8'h3C;
            do begin
                en_tick();
                step();
                if (done !== 1'b1) chk("b2b_wait", in_ready, 0);
                g++;
            end while (done !== 1'b1 && g < 200);
            chk("b2b_done", done, 1);
            chk("b2b_ready", in_ready, 1);
            en_tick();
            step();
            chk("b2b_taken", busy, 1);
            in_valid = 1'b0;
            wait_done();
            idle_ticks(1);
        end

        // reset after three bits of 0x0F
        period   = 1;
        in_data  = 8'h0F;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en_tick();
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", a, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hits", exp_hits, 0);
        chk("mid_rst_done", done, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            en_tick();
            step();
        end

        // random words, cadences and idle gaps
        for (int w = 0; w < 40; w++) begin
            int gap;
            period = $urandom_range(1, 3);
            gap    = $urandom_range(0, 3);
            for (int i = 0; i < gap; i++) begin
                en_tick();
                step();
            end
            in_data  = 8'($urandom);
            in_valid = 1'b1;
            wait_accept();
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            wait_done();
        end
        idle_ticks(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
